// File: rtl/dsp_norm_pkg.sv
// dsp_norm_pkg: shared widths, limits and types for the normalizer.
// Consumers import with: import dsp_norm_pkg::*;
package dsp_norm_pkg;

    localparam int DFLT_IN_W  = 32;
    localparam int DFLT_OUT_W = 16;
    localparam int DFLT_SH_W  = 4;

    localparam logic [DFLT_OUT_W-1:0] MANT_MAX = 16'h7FFF;

    typedef logic [DFLT_SH_W-1:0] sh_t;

    typedef struct packed {
        logic [DFLT_IN_W-1:0] data;
        sh_t                  sh;
    } s1_t;

    // Largest positive mantissa for an arbitrary output width.
    function automatic int mant_max_of(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/dsp_norm_lsc.sv
// dsp_norm_lsc: combinational redundant-sign counter.
// Output is the sign count clamped to 2^SH_W-1.
module dsp_norm_lsc
    import dsp_norm_pkg::*;
#(
    parameter int IN_W = DFLT_IN_W,
    parameter int SH_W = DFLT_SH_W
) (
    input  logic [IN_W-1:0] d,
    output logic [SH_W-1:0] sh
);

    localparam int CW = $clog2(IN_W);
    localparam logic [CW-1:0] SH_LIM = CW'((1 << SH_W) - 1);

    logic [CW-1:0] cnt;
    logic          run;

    // Walk down from just below the MSB while bits still match the sign.
    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = IN_W - 2; i >= 0; i--) begin
            if (run && (d[i] == d[IN_W-1])) begin
                cnt = cnt + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign sh = (cnt > SH_LIM) ? '1 : cnt[SH_W-1:0];

endmodule

// File: rtl/dsp_norm.sv
// dsp_norm: two-stage block-floating-point normalizer with valid/ready.
// Define DSP_NORM_RND_EN for round-half-up with positive saturation.
module dsp_norm
    import dsp_norm_pkg::*;
#(
    parameter int IN_W  = DFLT_IN_W,
    parameter int OUT_W = DFLT_OUT_W,
    parameter int SH_W  = DFLT_SH_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [SH_W-1:0]  out_sh,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             s1_valid;
    logic [IN_W-1:0]  s1_data;
    logic [SH_W-1:0]  s1_sh;
    logic [SH_W-1:0]  lsc_sh;

    logic             s2_free;
    logic             s1_adv;

    logic [IN_W-1:0]  shifted;
    logic [OUT_W-1:0] mant_t;
    logic [OUT_W-1:0] mant;

    dsp_norm_lsc #(
        .IN_W (IN_W),
        .SH_W (SH_W)
    ) u_lsc (
        .d  (in_data),
        .sh (lsc_sh)
    );

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;

    assign shifted = s1_data << s1_sh;
    assign mant_t  = shifted[IN_W-1 -: OUT_W];

`ifdef DSP_NORM_RND_EN
    localparam logic [OUT_W-1:0] SAT_POS = OUT_W'(mant_max_of(OUT_W));

    logic [OUT_W:0] rsum;
    logic           rbit;
    logic           ovf;
    logic           unused_lo;

    // Only a non-negative truncation can carry into the sign bit.
    always_comb begin
        rbit = shifted[IN_W-OUT_W-1];
        rsum = {mant_t[OUT_W-1], mant_t} + {{OUT_W{1'b0}}, rbit};
        ovf  = !mant_t[OUT_W-1] && rsum[OUT_W-1];
        mant = ovf ? SAT_POS : rsum[OUT_W-1:0];
    end

    assign unused_lo = ^{rsum[OUT_W], shifted[IN_W-OUT_W-2:0]};
`else
    logic unused_lo;

    assign mant      = mant_t;
    assign unused_lo = ^shifted[IN_W-OUT_W-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sh    <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_data <= in_data;
                s1_sh   <= lsc_sh;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sh    <= '0;
        end else begin
            if (s2_free) begin
                out_valid <= s1_valid;
            end
            if (s1_adv) begin
                out_data <= mant;
                out_sh   <= s1_sh;
            end
        end
    end

endmodule

// File: tb/tb_dsp_norm.sv
// tb_dsp_norm: scoreboard bench for the dsp_norm normalizer.
// Honours DSP_NORM_RND_EN for the rounding build.
module tb_dsp_norm;

    typedef struct packed {
        logic [3:0]  sh;
        logic [15:0] d;
    } exp_t;

`ifdef DSP_NORM_RND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_sh;
    logic        out_valid;
    logic        out_ready;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    dsp_norm dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sh    (out_sh),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Independent reference for the random stream.
    function automatic exp_t model(input logic [31:0] x);
        exp_t        e;
        int          n;
        int          v;
        logic [31:0] s;
        logic [15:0] t;
        n = 0;
        while (n < 31 && x[30-n] == x[31]) n++;
        if (n > 15) n = 15;
        s = x << n;
        t = s[31:16];
        if (RND) begin
            v = $signed(t) + int'(s[15]);
            if (v > 32767) v = 32767;
            t = v[15:0];
        end
        e.sh = n[3:0];
        e.d  = t;
        return e;
    endfunction

    // One clock: sample handshakes at the falling edge, return #1 after rise.
    task automatic tick(output bit acc, output bit got,
                        output logic [15:0] d, output logic [3:0] s);
        @(negedge clk);
        acc = in_valid && in_ready;
        got = out_valid && out_ready;
        d   = out_data;
        s   = out_sh;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b want=0", out_valid);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== 16'h0) begin
            failures++;
            $display("FAIL rst_data got=%h want=0000", out_data);
        end
        checks++;
        if (out_sh !== 4'h0) begin
            failures++;
            $display("FAIL rst_sh got=%h want=0", out_sh);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0001_2345;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL lat_accept got=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_early got=%b want=0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h48D1 || out_sh !== 4'hE) begin
            failures++;
            $display("FAIL lat_out got=%b/%h/%h want=1/48d1/e",
                     out_valid, out_data, out_sh);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] w[6];
        exp_t        e[6];
        int          idx;
        int          cyc;
        bit          acc;
        bit          got;
        logic [15:0] d;
        logic [3:0]  s;
        exp_t        x;
        w[0] = 32'h0001_2345; e[0] = {4'hE, 16'h48D1};
        w[1] = 32'hABCD_EF09; e[1] = {4'h0, RND ? 16'hABCE : 16'hABCD};
        w[2] = 32'h7FFF_8000; e[2] = {4'h0, 16'h7FFF};
        w[3] = 32'h0000_0000; e[3] = {4'hF, 16'h0000};
        w[4] = 32'hC000_0000; e[4] = {4'h1, 16'h8000};
        w[5] = 32'hFFFF_FFFF; e[5] = {4'hF, RND ? 16'h0000 : 16'hFFFF};
        idx = 0;
        cyc = 0;
        out_ready = 1'b1;
        while ((idx < 6 || q.size() != 0) && cyc < 30) begin
            in_valid = (idx < 6);
            in_data  = w[idx % 6];
            tick(acc, got, d, s);
            cyc++;
            if (acc) begin
                q.push_back(e[idx]);
                idx++;
            end
            if (got) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL vec_extra got=%h/%h want=none", s, d);
                end else begin
                    x = q.pop_front();
                    if (d !== x.d || s !== x.sh) begin
                        failures++;
                        $display("FAIL vec_out got=%h/%h want=%h/%h",
                                 s, d, x.sh, x.d);
                    end
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("FAIL vec_cycles got=%0d want=8", cyc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[3];
        exp_t        e[3];
        int          idx;
        int          cyc;
        bit          acc;
        bit          got;
        logic [15:0] d;
        logic [3:0]  s;
        exp_t        x;
        w[0] = 32'h0000_0001; e[0] = {4'hF, RND ? 16'h0001 : 16'h0000};
        w[1] = 32'h0000_0100; e[1] = {4'hF, 16'h0080};
        w[2] = 32'h0001_0000; e[2] = {4'hE, 16'h4000};
        idx = 0;
        q.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = (idx < 3);
            in_data  = w[idx % 3];
            tick(acc, got, d, s);
            if (acc) begin
                q.push_back(e[idx]);
                idx++;
            end
            if (k == 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== e[0].d || out_sh !== e[0].sh) begin
                    failures++;
                    $display("FAIL bp_hold_mid got=%b/%h/%h want=1/%h/%h",
                             out_valid, out_sh, out_data, e[0].sh, e[0].d);
                end
            end
        end
        checks++;
        if (idx != 2) begin
            failures++;
            $display("FAIL bp_accepts got=%0d want=2", idx);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready got=%b want=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== e[0].d || out_sh !== e[0].sh) begin
            failures++;
            $display("FAIL bp_hold_end got=%b/%h/%h want=1/%h/%h",
                     out_valid, out_sh, out_data, e[0].sh, e[0].d);
        end
        out_ready = 1'b1;
        cyc = 0;
        while ((idx < 3 || q.size() != 0) && cyc < 20) begin
            in_valid = (idx < 3);
            in_data  = w[idx % 3];
            tick(acc, got, d, s);
            cyc++;
            if (acc) begin
                q.push_back(e[idx]);
                idx++;
            end
            if (got) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra got=%h/%h want=none", s, d);
                end else begin
                    x = q.pop_front();
                    if (d !== x.d || s !== x.sh) begin
                        failures++;
                        $display("FAIL bp_out got=%h/%h want=%h/%h",
                                 s, d, x.sh, x.d);
                    end
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0 || idx != 3) begin
            failures++;
            $display("FAIL bp_timeout got=%0d left want=0", q.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] cur;
        int          sent;
        int          cyc;
        bit          acc;
        bit          got;
        logic [15:0] d;
        logic [3:0]  s;
        exp_t        x;
        q.delete();
        sent = 0;
        cyc  = 0;
        cur  = $urandom >> $urandom_range(0, 31);
        while ((sent < 300 || q.size() != 0) && cyc < 3000) begin
            in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
            in_data   = cur;
            out_ready = (sent >= 300) || ($urandom_range(0, 2) != 0);
            tick(acc, got, d, s);
            cyc++;
            if (acc) begin
                q.push_back(model(cur));
                sent++;
                cur = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) cur = ~cur;
            end
            if (got) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra got=%h/%h want=none", s, d);
                end else begin
                    x = q.pop_front();
                    if (d !== x.d || s !== x.sh) begin
                        failures++;
                        $display("FAIL rnd_out got=%h/%h want=%h/%h",
                                 s, d, x.sh, x.d);
                    end
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0 || sent != 300) begin
            failures++;
            $display("FAIL rnd_timeout got=%0d sent want=300", sent);
        end
    endtask

    task automatic test_reset_mid();
        int          idx;
        int          stale;
        bit          acc;
        bit          got;
        logic [15:0] d;
        logic [3:0]  s;
        exp_t        x;
        q.delete();
        idx = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 6 && idx < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_0100 << idx;
            tick(acc, got, d, s);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 2 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_fill got=%0d/%b want=2/1", idx, out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sh !== 4'h0) begin
            failures++;
            $display("FAIL rm_async got=%b/%h/%h want=0/0000/0",
                     out_valid, out_data, out_sh);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            tick(acc, got, d, s);
            if (got) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL rm_stale got=%0d want=0", stale);
        end
        in_valid = 1'b1;
        in_data  = 32'hC000_0000;
        tick(acc, got, d, s);
        in_valid = 1'b0;
        if (acc) q.push_back({4'h1, 16'h8000});
        for (int k = 0; k < 6 && q.size() != 0; k++) begin
            tick(acc, got, d, s);
            if (got) begin
                checks++;
                x = q.pop_front();
                if (d !== x.d || s !== x.sh) begin
                    failures++;
                    $display("FAIL rm_after got=%h/%h want=%h/%h",
                             s, d, x.sh, x.d);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rm_timeout got=%0d left want=0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
